// File: rtl/eva_axi_wr_master.sv
// AXI write-burst master: command/data stream to 128-bit AW/W, one burst in flight, data FIFO of FIFO_DEPTH beats.
// Latency: awvalid one cycle after command acceptance; wvalid one cycle after a beat lands in an empty FIFO.
// Backpressure: din_ready = !fifo_full; W outputs hold while wready=0. Macro EVA_WR_ALIGN_CHK_EN rejects unaligned commands.
module eva_axi_wr_master #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] ID_INIT    = 4'd0
) (
    input  logic         aclk,
    input  logic         arest,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [31:0]  cmd_addr,
    input  logic [5:0]   cmd_len,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [127:0] din_data,
    input  logic [15:0]  din_strb,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [5:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awport,
    output logic [3:0]   awregion,
    output logic [3:0]   awqos,
    output logic [7:0]   awuser,
    output logic         wvalid,
    input  logic         wready,
    output logic         wlast,
    output logic [3:0]   wid,
    output logic [127:0] wdata,
    output logic [15:0]  wstrb,
    output logic         busy,
    output logic         burst_done,
    output logic         err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t        r_state;
    logic          r_cmd_ready;
    logic          r_awvalid;
    logic [31:0]   r_awaddr;
    logic [5:0]    r_awlen;
    logic [3:0]    r_awid;
    logic [3:0]    r_id_cnt;
    logic [5:0]    r_beat_cnt;
    logic          r_burst_done;
    logic          r_err;

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [143:0]  r_mem [FIFO_DEPTH];

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_wvalid;
    logic          w_wlast;
    logic          w_cmd_fire;
    logic          w_misaligned;
    logic [143:0]  w_head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = din_valid && !w_full;
    assign w_pop   = w_wvalid && wready;
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign w_wvalid   = (r_state == S_DATA) && !w_empty;
    assign w_wlast    = w_wvalid && (r_beat_cnt == r_awlen);
    assign w_cmd_fire = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;

`ifdef EVA_WR_ALIGN_CHK_EN
    assign w_misaligned = (cmd_addr[3:0] != 4'h0);
`else
    logic w_unused_addr_lsb;
    assign w_misaligned      = 1'b0;
    assign w_unused_addr_lsb = ^cmd_addr[3:0];
`endif

    always_ff @(posedge aclk) begin
        if (arest) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {din_data, din_strb};
    end

    always_ff @(posedge aclk) begin
        if (arest) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_awvalid    <= 1'b0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_awid       <= '0;
            r_id_cnt     <= ID_INIT;
            r_beat_cnt   <= '0;
            r_burst_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        if (w_misaligned) begin
                            r_err <= 1'b1;
                        end else begin
                            // The slave computes INCR addresses itself, so only the 16-byte aligned base is sent.
                            r_awaddr    <= {cmd_addr[31:4], 4'h0};
                            r_awlen     <= cmd_len;
                            r_awid      <= r_id_cnt;
                            r_awvalid   <= 1'b1;
                            r_cmd_ready <= 1'b0;
                            r_state     <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (awready) begin
                        r_awvalid  <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_pop) begin
                        r_beat_cnt <= r_beat_cnt + 6'd1;
                        // No B channel downstream: the wlast handshake ends the burst.
                        if (w_wlast) begin
                            r_state      <= S_IDLE;
                            r_burst_done <= 1'b1;
                            r_id_cnt     <= r_id_cnt + 4'd1;
                            r_cmd_ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign din_ready  = !w_full;
    assign awvalid    = r_awvalid;
    assign awid       = r_awid;
    assign awaddr     = r_awaddr;
    assign awlen      = r_awlen;
    assign awsize     = 3'b100;
    assign awburst    = 2'b01;
    assign awlock     = 1'b0;
    assign awcache    = 4'h0;
    assign awport     = 3'h0;
    assign awregion   = 4'h0;
    assign awqos      = 4'h0;
    assign awuser     = 8'h00;
    assign wvalid     = w_wvalid;
    assign wlast      = w_wlast;
    assign wid        = r_awid;
    assign wdata      = w_head[143:16];
    assign wstrb      = w_head[15:0];
    assign busy       = (r_state != S_IDLE);
    assign burst_done = r_burst_done;
    assign err        = r_err;

endmodule

// File: tb/tb_eva_axi_wr_master.sv
// Directed bench for eva_axi_wr_master: inputs driven and outputs sampled on the falling edge.
module tb_eva_axi_wr_master;

    logic         aclk;
    logic         arest;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic [5:0]   cmd_len;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] din_data;
    logic [15:0]  din_strb;
    logic         awvalid;
    logic         awready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [5:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awlock;
    logic [3:0]   awcache;
    logic [2:0]   awport;
    logic [3:0]   awregion;
    logic [3:0]   awqos;
    logic [7:0]   awuser;
    logic         wvalid;
    logic         wready;
    logic         wlast;
    logic [3:0]   wid;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         busy;
    logic         burst_done;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [127:0] got_data [$];
    logic [15:0]  got_strb [$];
    logic         got_last [$];
    logic [3:0]   got_wid  [$];
    logic [3:0]   got_awid;
    int           aw_cnt;
    int           done_cnt;
    bit           early_w;

    eva_axi_wr_master #(.FIFO_DEPTH(4), .ID_INIT(4'd0)) dut (
        .aclk(aclk), .arest(arest),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_strb(din_strb),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awport(awport),
        .awregion(awregion), .awqos(awqos), .awuser(awuser),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .busy(busy), .burst_done(burst_done), .err(err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [127:0] mk_data(input int i);
        return {32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i), 32'hC000_0000 | 32'(i), 32'hD000_0000 | 32'(i)};
    endfunction

    function automatic logic [15:0] mk_strb(input int i);
        return 16'hFFFF ^ 16'(i);
    endfunction

    task automatic do_reset();
        arest = 1'b1;
        repeat (2) @(negedge aclk);
        arest = 1'b0;
        @(negedge aclk);
    endtask

    task automatic push_beat(input int i);
        logic acc;
        din_valid = 1'b1;
        din_data  = mk_data(i);
        din_strb  = mk_strb(i);
        for (int c = 0; c < 200; c++) begin
            acc = din_ready;
            @(negedge aclk);
            if (acc) begin
                din_valid = 1'b0;
                return;
            end
        end
        din_valid = 1'b0;
        checks++; errors++;
        $display("FAIL push_timeout beat %0d: din_ready never rose, required 1", i);
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [5:0] len);
        logic acc;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int c = 0; c < 200; c++) begin
            acc = cmd_ready;
            @(negedge aclk);
            if (acc) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        checks++; errors++;
        $display("FAIL cmd_timeout addr %h: cmd_ready never rose, required 1", addr);
    endtask

    // Observes AW/W handshakes until burst_done is seen (returning on that cycle) or the budget runs out.
    task automatic collect(input int max_cycles);
        got_data.delete(); got_strb.delete(); got_last.delete(); got_wid.delete();
        aw_cnt = 0; done_cnt = 0; early_w = 1'b0; got_awid = 4'hx;
        for (int c = 0; c < max_cycles; c++) begin
            if (awvalid && awready) begin
                aw_cnt++;
                got_awid = awid;
            end
            if (wvalid && aw_cnt == 0) early_w = 1'b1;
            if (wvalid && wready) begin
                got_data.push_back(wdata);
                got_strb.push_back(wstrb);
                got_last.push_back(wlast);
                got_wid.push_back(wid);
            end
            if (burst_done) begin
                done_cnt++;
                return;
            end
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        arest = 1'b1;
        repeat (2) @(negedge aclk);
        checks++; if ({awvalid, wvalid, wlast, burst_done, err, cmd_ready, busy} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b required 0000000", {awvalid, wvalid, wlast, burst_done, err, cmd_ready, busy}); end
        checks++; if ({awaddr, awlen, awid} !== 42'h0) begin errors++; $display("FAIL reset_aw got addr %h len %0d id %0d required 0", awaddr, awlen, awid); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b required 1", din_ready); end
        checks++; if ({awsize, awburst} !== 5'b100_01) begin errors++; $display("FAIL aw_consts got size %b burst %b required 100 01", awsize, awburst); end
        checks++; if ({awlock, awcache, awport, awregion, awqos, awuser} !== 24'h0) begin errors++; $display("FAIL aw_zero_consts got nonzero required 0"); end
        arest = 1'b0;
        @(negedge aclk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %b required 1", cmd_ready); end
    endtask

    task automatic test_basic_burst();
        awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 4; i++) push_beat(10 + i);
        send_cmd(32'h0000_1000, 6'd3);
        checks++; if (awvalid !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_aw_latency got awvalid %b cmd_ready %b busy %b required 1 0 1", awvalid, cmd_ready, busy); end
        checks++; if (awaddr !== 32'h0000_1000 || awlen !== 6'd3) begin errors++; $display("FAIL basic_aw_fields got %h/%0d required 00001000/3", awaddr, awlen); end
        collect(40);
        checks++; if (got_awid !== 4'd0 || aw_cnt !== 1) begin errors++; $display("FAIL basic_awid got %0d (hs %0d) required 0 (1)", got_awid, aw_cnt); end
        checks++; if (got_data.size() !== 4 || done_cnt !== 1 || early_w) begin errors++; $display("FAIL basic_beats got %0d beats done %0d early %b required 4 1 0", got_data.size(), done_cnt, early_w); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_data[i] !== mk_data(10 + i) || got_strb[i] !== mk_strb(10 + i) || got_last[i] !== (i == 3) || got_wid[i] !== 4'd0) begin
                errors++; $display("FAIL basic_beat%0d got %h/%h last %b wid %0d required %h/%h last %b wid 0", i, got_data[i], got_strb[i], got_last[i], got_wid[i], mk_data(10 + i), mk_strb(10 + i), i == 3);
            end
        end
        @(negedge aclk);
        checks++; if (burst_done !== 1'b0 || wvalid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got done %b wvalid %b cmd_ready %b required 0 0 1", burst_done, wvalid, cmd_ready); end
    endtask

    task automatic test_aw_stall();
        awready = 1'b0; wready = 1'b1;
        push_beat(20);
        send_cmd(32'h0000_1000, 6'd0);
        for (int c = 0; c < 5; c++) begin
            checks++; if (awvalid !== 1'b1 || awaddr !== 32'h0000_1000 || awlen !== 6'd0 || wvalid !== 1'b0) begin
                errors++; $display("FAIL aw_stall_c%0d got awvalid %b addr %h len %0d wvalid %b required 1 00001000 0 0", c, awvalid, awaddr, awlen, wvalid);
            end
            @(negedge aclk);
        end
        awready = 1'b1;
        collect(20);
        checks++; if (aw_cnt !== 1 || early_w || got_data.size() !== 1 || done_cnt !== 1) begin errors++; $display("FAIL aw_stall_burst got hs %0d early %b beats %0d done %0d required 1 0 1 1", aw_cnt, early_w, got_data.size(), done_cnt); end
        checks++; if (got_data[0] !== mk_data(20) || got_last[0] !== 1'b1) begin errors++; $display("FAIL aw_stall_beat got %h last %b required %h last 1", got_data[0], got_last[0], mk_data(20)); end
    endtask

    task automatic test_w_backpressure();
        logic [3:0] pat;
        awready = 1'b1; wready = 1'b0;
        pat = 4'b1001;
        push_beat(30); push_beat(31);
        send_cmd(32'h0000_2000, 6'd1);
        @(negedge aclk);
        for (int c = 0; c < 4; c++) begin
            wready = pat[3 - c];
            checks++; if (wvalid !== 1'b1 || wdata !== mk_data(c == 0 ? 30 : 31) || wlast !== (c != 0)) begin
                errors++; $display("FAIL bp_cycle%0d got wvalid %b data %h last %b required 1 %h %b", c, wvalid, wdata, wlast, mk_data(c == 0 ? 30 : 31), c != 0);
            end
            @(negedge aclk);
        end
        checks++; if (burst_done !== 1'b1 || wvalid !== 1'b0) begin errors++; $display("FAIL bp_done got done %b wvalid %b required 1 0", burst_done, wvalid); end
        wready = 1'b1;
    endtask

    task automatic test_fifo_fill();
        for (int i = 0; i < 4; i++) push_beat(40 + i);
        checks++; if (din_ready !== 1'b0 || wvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fill_full got din_ready %b wvalid %b busy %b required 0 0 0", din_ready, wvalid, busy); end
        awready = 1'b1; wready = 1'b1;
        fork
            begin
                push_beat(44);
                push_beat(45);
            end
            begin
                send_cmd(32'h0000_4000, 6'd5);
                collect(60);
            end
        join
        checks++; if (got_data.size() !== 6 || done_cnt !== 1) begin errors++; $display("FAIL fill_beats got %0d done %0d required 6 1", got_data.size(), done_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got_data[i] !== mk_data(40 + i) || got_last[i] !== (i == 5)) begin
                errors++; $display("FAIL fill_beat%0d got %h last %b required %h last %b", i, got_data[i], got_last[i], mk_data(40 + i), i == 5);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        awready = 1'b1; wready = 1'b1;
        fork
            for (int b = 0; b < 17; b++) push_beat(100 + b);
            for (int b = 0; b < 17; b++) begin
                send_cmd(32'h0000_8000 + 32'(b * 16), 6'd0);
                collect(40);
                checks++; if (got_awid !== 4'(b) || got_wid[0] !== 4'(b)) begin errors++; $display("FAIL b2b_id%0d got awid %0d wid %0d required %0d", b, got_awid, got_wid[0], 4'(b)); end
                checks++; if (got_data.size() !== 1 || got_data[0] !== mk_data(100 + b) || got_last[0] !== 1'b1 || done_cnt !== 1) begin
                    errors++; $display("FAIL b2b_beat%0d got %0d beats data %h last %b required 1 %h 1", b, got_data.size(), got_data[0], got_last[0], mk_data(100 + b));
                end
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b required 1", b, cmd_ready); end
            end
        join
    endtask

    task automatic test_align();
        awready = 1'b1; wready = 1'b1;
`ifdef EVA_WR_ALIGN_CHK_EN
        send_cmd(32'h0000_1004, 6'd0);
        checks++; if (err !== 1'b1 || awvalid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL align_reject got err %b awvalid %b busy %b cmd_ready %b required 1 0 0 1", err, awvalid, busy, cmd_ready); end
        @(negedge aclk);
        checks++; if (err !== 1'b0 || awvalid !== 1'b0) begin errors++; $display("FAIL align_pulse got err %b awvalid %b required 0 0", err, awvalid); end
`else
        push_beat(60);
        send_cmd(32'h0000_1004, 6'd0);
        checks++; if (awvalid !== 1'b1 || awaddr !== 32'h0000_1000 || err !== 1'b0) begin errors++; $display("FAIL align_force got awvalid %b addr %h err %b required 1 00001000 0", awvalid, awaddr, err); end
        collect(20);
        checks++; if (got_data.size() !== 1 || got_data[0] !== mk_data(60) || done_cnt !== 1) begin errors++; $display("FAIL align_burst got %0d beats done %0d required 1 1", got_data.size(), done_cnt); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        awready = 1'b1; wready = 1'b0;
        push_beat(70); push_beat(71);
        send_cmd(32'h0000_3000, 6'd3);
        @(negedge aclk);
        checks++; if (wvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got wvalid %b busy %b required 1 1", wvalid, busy); end
        arest = 1'b1;
        @(negedge aclk);
        checks++; if ({awvalid, wvalid, wlast, burst_done, err, cmd_ready, busy} !== 7'b0 || {awaddr, awlen, awid} !== 42'h0) begin
            errors++; $display("FAIL mid_reset got ctrl %b addr %h len %0d id %0d required 0", {awvalid, wvalid, wlast, burst_done, err, cmd_ready, busy}, awaddr, awlen, awid);
        end
        arest = 1'b0;
        wready = 1'b1;
        @(negedge aclk);
        checks++; if (cmd_ready !== 1'b1 || din_ready !== 1'b1 || wvalid !== 1'b0) begin errors++; $display("FAIL mid_release got cmd_ready %b din_ready %b wvalid %b required 1 1 0", cmd_ready, din_ready, wvalid); end
        send_cmd(32'h0000_5000, 6'd0);
        checks++; if (awid !== 4'd0) begin errors++; $display("FAIL mid_id got %0d required 0", awid); end
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            checks++; if (wvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_fifo_empty%0d got wvalid %b busy %b required 0 1", c, wvalid, busy); end
        end
        push_beat(72);
        collect(10);
        checks++; if (got_data.size() !== 1 || got_data[0] !== mk_data(72) || done_cnt !== 1) begin errors++; $display("FAIL mid_after got %0d beats data %h required 1 %h", got_data.size(), got_data[0], mk_data(72)); end
    endtask

    initial begin
        arest = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        din_valid = 1'b0; din_data = '0; din_strb = '0;
        awready = 1'b0; wready = 1'b0;
        @(negedge aclk);
        test_reset();
        test_basic_burst();
        test_aw_stall();
        test_w_backpressure();
        test_fifo_fill();
        test_back_to_back();
        test_align();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
